// File: rtl/uart_tx_packetizer.sv
// Frames a latched message ID and payload as SOF, ID, LEN, payload (MSB byte first), CSUM
// and feeds it byte-by-byte into the TX FIFO push interface, stalling while the FIFO is full.
module uart_tx_packetizer #(
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter logic [7:0]  SOF_BYTE      = 8'hAA
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [7:0]                 msg_id,
  input  logic [8*PAYLOAD_BYTES-1:0] payload,
  input  logic                       tx_fifo_full,
  output logic [7:0]                 tx_data,
  output logic                       push,
  output logic                       ready,
  output logic                       done
);

  localparam int unsigned CNT_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [7:0]       LEN_BYTE = 8'(PAYLOAD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_ID,
    S_LEN,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  state_t                     state, state_n;
  logic [CNT_W-1:0]           cnt;
  logic [7:0]                 acc;
  logic [7:0]                 id_q;
  logic [8*PAYLOAD_BYTES-1:0] payload_q;
  logic [7:0]                 pl_byte;

  assign ready = (state == S_IDLE);
  // A byte is accepted in exactly the cycles push is high, so push doubles as the advance strobe.
  assign push  = (state != S_IDLE) && !tx_fifo_full;

  // Counter 0 selects the most significant payload byte.
  always_comb begin
    pl_byte = '0;
    for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
      if (cnt == CNT_W'(i)) pl_byte = payload_q[8*(int'(PAYLOAD_BYTES)-1-i) +: 8];
    end
  end

  // NOTE: every output of this block gets a default before the case, so no latches are inferred.
  always_comb begin
    state_n = state;
    tx_data = 8'h00;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_SOF;
      end
      S_SOF: begin
        tx_data = SOF_BYTE;
        if (push) state_n = S_ID;
      end
      S_ID: begin
        tx_data = id_q;
        if (push) state_n = S_LEN;
      end
      S_LEN: begin
        tx_data = LEN_BYTE;
        if (push) state_n = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        tx_data = pl_byte;
        if (push && cnt == LAST_CNT) state_n = S_CSUM;
      end
      S_CSUM: begin
        tx_data = acc;
        if (push) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= 8'h00;
      id_q      <= 8'h00;
      payload_q <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= push && (state == S_CSUM);
      if (state == S_IDLE && start) begin
        id_q      <= msg_id;
        payload_q <= payload;
        acc       <= 8'h00;
        cnt       <= '0;
      end else if (push) begin
        // The 8-bit accumulator wraps naturally; SOF never contributes.
        unique case (state)
          S_ID:      acc <= acc + id_q;
          S_LEN:     acc <= acc + LEN_BYTE;
          S_PAYLOAD: begin
            acc <= acc + pl_byte;
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Directed bench for uart_tx_packetizer (PAYLOAD_BYTES=4): frame content, timing, stall,
// ignored start while busy, back-to-back frames and mid-frame reset.
module tb_uart_tx_packetizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  msg_id;
  logic [31:0] payload;
  logic        tx_fifo_full;
  logic [7:0]  tx_data;
  logic        push;
  logic        ready;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [7:0] got_b[$];
  int         got_t[$];
  int         done_rel;

  uart_tx_packetizer #(.PAYLOAD_BYTES(4), .SOF_BYTE(8'hAA)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .msg_id       (msg_id),
    .payload      (payload),
    .tx_fifo_full (tx_fifo_full),
    .tx_data      (tx_data),
    .push         (push),
    .ready        (ready),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference frame byte i for a 4-byte payload.
  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] id, input logic [31:0] pl);
    logic [7:0] cs;
    cs = id + 8'h04 + pl[31:24] + pl[23:16] + pl[15:8] + pl[7:0];
    case (i)
      0:       return 8'hAA;
      1:       return id;
      2:       return 8'h04;
      3:       return pl[31:24];
      4:       return pl[23:16];
      5:       return pl[15:8];
      6:       return pl[7:0];
      default: return cs;
    endcase
  endfunction

  // Presents start for one edge; returns just after that edge (cycle 1 of the frame).
  task automatic send(input logic [7:0] id, input logic [31:0] pl);
    start   = 1'b1;
    msg_id  = id;
    payload = pl;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Steps through frame cycles, recording pushes, until done. Returns at the negedge of the done cycle.
  task automatic collect(input int fs, input int fl, input logic [7:0] stall_data, input int poke_rel);
    int rel;
    rel = 1;
    got_b.delete();
    got_t.delete();
    done_rel = -1;
    while (rel <= 40) begin
      tx_fifo_full = (rel >= fs) && (rel < fs + fl);
      if (rel == poke_rel) begin
        start   = 1'b1;
        msg_id  = 8'h55;
        payload = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        done_rel = rel;
        check("ready_in_done_cycle", 32'(ready), 32'd1);
        break;
      end
      check("ready_low_busy", 32'(ready), 32'd0);
      if (tx_fifo_full) begin
        check("stall_push", 32'(push), 32'd0);
        check("stall_data", 32'(tx_data), 32'(stall_data));
      end
      if (push) begin
        got_b.push_back(tx_data);
        got_t.push_back(rel);
      end
      @(posedge clk);
      #1;
      rel++;
    end
    tx_fifo_full = 1'b0;
    start        = 1'b0;
    if (done_rel < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic verify(input logic [7:0] id, input logic [31:0] pl, input int stall, input int exp_done);
    check("byte_count", 32'(got_b.size()), 32'd8);
    for (int i = 0; i < got_b.size() && i < 8; i++) begin
      check($sformatf("byte%0d", i), 32'(got_b[i]), 32'(exp_byte(i, id, pl)));
      check($sformatf("time%0d", i), 32'(got_t[i]), 32'(i + 1 + ((i >= 2) ? stall : 0)));
    end
    check("done_cycle", 32'(done_rel), 32'(exp_done));
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    msg_id       = 8'h00;
    payload      = 32'h0;
    tx_fifo_full = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_push", 32'(push), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single frame: AA 10 04 01 02 03 04 1E, done at cycle 9.
    send(8'h10, 32'h01020304);
    collect(0, 0, 8'h00, 0);
    verify(8'h10, 32'h01020304, 0, 9);
    if (got_b.size() == 8) check("csum_1E", 32'(got_b[7]), 32'h1E);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_no_push", 32'(push), 32'd0);
    @(posedge clk);
    #1;

    // Checksum wrap, then a start in the done cycle runs the next frame back to back.
    send(8'hF0, 32'h80808080);
    collect(0, 0, 8'h00, 0);
    verify(8'hF0, 32'h80808080, 0, 9);
    if (got_b.size() == 8) check("csum_F4", 32'(got_b[7]), 32'hF4);
    send(8'h21, 32'h11223344);
    collect(0, 0, 8'h00, 0);
    verify(8'h21, 32'h11223344, 0, 9);
    @(posedge clk);
    #1;

    // Back-pressure: FIFO full for 5 cycles while LEN is pending.
    send(8'h33, 32'hA1B2C3D4);
    collect(3, 5, 8'h04, 0);
    verify(8'h33, 32'hA1B2C3D4, 5, 14);
    @(posedge clk);
    #1;

    // Start during payload phase with other data must be ignored.
    send(8'h44, 32'h0A0B0C0D);
    collect(0, 0, 8'h00, 5);
    verify(8'h44, 32'h0A0B0C0D, 0, 9);
    @(posedge clk);
    #1;

    // Reset after the ID byte has been pushed.
    send(8'h66, 32'h12345678);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_push", 32'(push), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_data", 32'(tx_data), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_push", 32'(push), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("postrst_no_push", 32'(push), 32'd0);
    check("postrst_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    send(8'h77, 32'hCAFEF00D);
    collect(0, 0, 8'h00, 0);
    verify(8'h77, 32'hCAFEF00D, 0, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
